// File: rtl/a23_pkg.sv
// a23_pkg: shared run-controller state encoding and default sizes
package a23_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
   localparam int NUM_CH_DEF     = 3;
   localparam int DEPTH_DEF      = 64;
   localparam int OUT_SIZE_DEF   = 64;
   localparam int WORD_W_DEF     = 32;
   localparam int MAX_CYCLES_DEF = 2**20;
   localparam int CC_W_DEF       = 32;
endpackage

// File: rtl/a23_img_streamer.sv
// a23_img_streamer: snapshots the core output image and streams it word by word
//   clk, rst_n          clock, asynchronous active-low reset
//   active              controller is draining; drives out_valid
//   capture             load img into the snapshot and rewind to word 0
//   img                 flat output image, word 0 in the LSBs
//   out_valid/ready/last, out_data   result-stream handshake
//   last_xfer           final word accepted this cycle
module a23_img_streamer
   import a23_pkg::*;
#(
   parameter int OUT_SIZE = OUT_SIZE_DEF,
   parameter int WORD_W   = WORD_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       active,
   input  logic                       capture,
   input  logic [OUT_SIZE*WORD_W-1:0] img,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic                       out_last,
   output logic [WORD_W-1:0]          out_data,
   output logic                       last_xfer
);
   localparam int JW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1;
   logic [OUT_SIZE*WORD_W-1:0] snap;
   logic [JW-1:0]              j;
   assign out_valid = active;
   assign out_last  = active && (j == JW'(OUT_SIZE - 1));
   // gated so the stream reads zero whenever nothing is offered
   assign out_data  = active ? snap[j*WORD_W +: WORD_W] : '0;
   assign last_xfer = out_valid && out_ready && out_last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         snap <= '0;
         j    <= '0;
      end else if (capture) begin
         snap <= img;
         j    <= '0;
      end else if (out_valid && out_ready)
         j <= out_last ? '0 : j + JW'(1);
endmodule

// File: rtl/a23_run_ctrl.sv
// a23_run_ctrl: loads input images, runs the core to termination/timeout, streams the result
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           begin load/run (honoured in IDLE or DONE)
//   load_valid/ready, load_data     load stream, channel-major word-minor
//   init_img                        registered input images
//   core_rst                        core reset, low only while running
//   terminate, o                    core completion flag and output image
//   out_valid/ready/last, out_data  result stream
//   cycle_count, done, timeout      run statistics and status
module a23_run_ctrl
   import a23_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int OUT_SIZE   = OUT_SIZE_DEF,
   parameter int WORD_W     = WORD_W_DEF,
   parameter int MAX_CYCLES = MAX_CYCLES_DEF,
   parameter int CC_W       = CC_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [WORD_W-1:0]              load_data,
   output logic [NUM_CH*DEPTH*WORD_W-1:0] init_img,
   output logic                           core_rst,
   input  logic                           terminate,
   input  logic [OUT_SIZE*WORD_W-1:0]     o,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [WORD_W-1:0]              out_data,
   output logic [CC_W-1:0]                cycle_count,
   output logic                           done,
   output logic                           timeout
);
   localparam int NW = NUM_CH * DEPTH;
   localparam int KW = NW > 1 ? $clog2(NW) : 1;
   state_t        state, nxt;
   logic [KW-1:0] k;
   logic          accept, capture, last_xfer, go;
   assign go         = (state == IDLE || state == DONE) && start;
   assign accept     = state == LOAD && load_valid;
   // terminate wins over the timeout; both freeze the count and snapshot o
   assign capture    = state == RUN && (terminate || cycle_count == CC_W'(MAX_CYCLES));
   assign load_ready = state == LOAD;
   assign core_rst   = state != RUN;
   assign done       = state == DONE;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: nxt = start ? LOAD : state;
         LOAD:       nxt = (accept && k == KW'(NW - 1)) ? RUN : LOAD;
         RUN:        nxt = capture ? DRAIN : RUN;
         DRAIN:      nxt = last_xfer ? DONE : DRAIN;
         default:    nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         k           <= '0;
         init_img    <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         if (go) begin
            k           <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
         end
         if (accept) begin
            init_img[k*WORD_W +: WORD_W] <= load_data;
            k                            <= k + KW'(1);
         end
         if (state == RUN && !terminate) begin
            if (cycle_count == CC_W'(MAX_CYCLES)) timeout <= 1'b1;
            else if (cycle_count != '1)           cycle_count <= cycle_count + CC_W'(1);
         end
      end
   a23_img_streamer #(.OUT_SIZE(OUT_SIZE), .WORD_W(WORD_W)) u_str (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (state == DRAIN),
      .capture   (capture),
      .img       (o),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .last_xfer (last_xfer)
   );
endmodule
